// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the lane datapath
// Purpose: word and register-select types, vector register file FSM states
//          and the bank-interleave helper.
package cpu_types_pkg;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef enum logic [1:0] {
      IDLE,
      CONFLICT,
      RESP
   } vrf_state_t;

   // Registers are interleaved, so the bank is simply the low log2(nbanks) bits.
   function automatic regbits_t bank_of(regbits_t r, int nbanks);
      return r & regbits_t'(nbanks - 1);
   endfunction

endpackage

// File: rtl/vrf_bank.sv
// rtl/vrf_bank.sv - one 1R1W bank of the vector register file
// Purpose: DEPTH entries of THREADS words, per-lane write enable,
//          combinational read with write-first bypass.
// Ports:
//   CLK, nRST  clock, asynchronous active-low reset (clears all entries)
//   i_wen      per-lane write enable (already gated for bank/r0 by the top)
//   i_widx     entry written
//   i_wdata    per-lane write data
//   i_ridx     entry read
//   o_rdata    per-lane read data
module vrf_bank
   import cpu_types_pkg::*;
#(
   parameter int THREADS = 4,
   parameter int DEPTH   = 8,
   parameter int IDX_W   = 3
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic [THREADS-1:0]       i_wen,
   input  logic [IDX_W-1:0]         i_widx,
   input  word_t [THREADS-1:0]      i_wdata,
   input  logic [IDX_W-1:0]         i_ridx,
   output word_t [THREADS-1:0]      o_rdata
);

   word_t [THREADS-1:0] r_mem [DEPTH];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int e = 0; e < DEPTH; e++) begin
            r_mem[e] <= '0;
         end
      end else begin
         for (int l = 0; l < THREADS; l++) begin
            if (i_wen[l]) begin
               r_mem[i_widx][l] <= i_wdata[l];
            end
         end
      end
   end

   // Write-first: a lane being written this cycle returns the new data.
   always_comb begin
      o_rdata = '0;
      for (int l = 0; l < THREADS; l++) begin
         o_rdata[l] = (i_wen[l] && (i_widx == i_ridx)) ? i_wdata[l] : r_mem[i_ridx][l];
      end
   end

endmodule

// File: rtl/vector_register_file_banked.sv
// rtl/vector_register_file_banked.sv - banked SIMT vector register file
// Purpose: two-operand reads over single-read-port interleaved banks with a
//          valid/ready request/response handshake; same-bank operand pairs
//          take one extra cycle and are counted.
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   req_valid/req_ready       read request handshake
//   req_rsel1/req_rsel2       source registers
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata1/rsp_rdata2     registered per-lane operands
//   wen/wsel/wdata            per-lane write port (never stalled)
//   conflict_count            saturating count of conflicting requests
module vector_register_file_banked
   import cpu_types_pkg::*;
#(
   parameter int THREADS = 4,
   parameter int NREGS   = 32,
   parameter int NBANKS  = 4,
   parameter int CNT_W   = 16
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  regbits_t             req_rsel1,
   input  regbits_t             req_rsel2,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output word_t [THREADS-1:0]  rsp_rdata1,
   output word_t [THREADS-1:0]  rsp_rdata2,
   input  logic [THREADS-1:0]   wen,
   input  regbits_t             wsel,
   input  word_t [THREADS-1:0]  wdata,
   output logic [CNT_W-1:0]     conflict_count
);

   localparam int SH     = $clog2(NBANKS);
   localparam int BANK_W = (SH > 0) ? SH : 1;
   localparam int DEPTH  = NREGS / NBANKS;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [REG_W:0] NREGS_X = (REG_W+1)'(NREGS);

   function automatic logic [BANK_W-1:0] bsel(regbits_t r);
      return BANK_W'(bank_of(r, NBANKS));
   endfunction

   function automatic logic [IDX_W-1:0] idx(regbits_t r);
      return IDX_W'(r >> SH);
   endfunction

   // Only nonzero, in-range registers touch a bank; everything else reads 0.
   function automatic logic live(regbits_t r);
      return (r != '0) && ({1'b0, r} < NREGS_X);
   endfunction

   vrf_state_t                      r_state;
   vrf_state_t                      w_next;
   regbits_t                        r_rsel2;
   word_t [THREADS-1:0]             r_hold1;
   word_t [THREADS-1:0]             r_rdata1;
   word_t [THREADS-1:0]             r_rdata2;
   logic [CNT_W-1:0]                r_cnt;

   logic                            w_accept;
   logic                            w_conflict;
   regbits_t                        w_rs2;
   logic [IDX_W-1:0]                w_widx;
   logic [IDX_W-1:0]                w_ridx     [NBANKS];
   logic [THREADS-1:0]              w_bank_wen [NBANKS];
   word_t [NBANKS-1:0][THREADS-1:0] w_bank_rdata;
   word_t [THREADS-1:0]             w_op1;
   word_t [THREADS-1:0]             w_op2;

   assign req_ready  = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
   assign w_accept   = req_valid && req_ready;
   assign w_conflict = (bsel(req_rsel1) == bsel(req_rsel2)) && (req_rsel1 != req_rsel2)
                       && (req_rsel1 != '0) && (req_rsel2 != '0);

   // In CONFLICT the second read comes from the captured rsel2, not the bus.
   assign w_rs2  = (r_state == CONFLICT) ? r_rsel2 : req_rsel2;
   assign w_widx = idx(wsel);

   // Bank port routing: without a conflict the two operands never need the
   // same port except when they name the same register, so operand 1 gets
   // priority and operand 2 reads whatever bank is left.
   always_comb begin
      for (int b = 0; b < NBANKS; b++) begin
         w_ridx[b]     = '0;
         w_bank_wen[b] = '0;
         if (r_state == CONFLICT) begin
            if (bsel(r_rsel2) == BANK_W'(b)) w_ridx[b] = idx(r_rsel2);
         end else if (live(req_rsel1) && (bsel(req_rsel1) == BANK_W'(b))) begin
            w_ridx[b] = idx(req_rsel1);
         end else if (bsel(req_rsel2) == BANK_W'(b)) begin
            w_ridx[b] = idx(req_rsel2);
         end
         if (live(wsel) && (bsel(wsel) == BANK_W'(b))) w_bank_wen[b] = wen;
      end
   end

   for (genvar gb = 0; gb < NBANKS; gb++) begin : g_bank
      vrf_bank #(
         .THREADS (THREADS),
         .DEPTH   (DEPTH),
         .IDX_W   (IDX_W)
      ) u_bank (
         .CLK     (CLK),
         .nRST    (nRST),
         .i_wen   (w_bank_wen[gb]),
         .i_widx  (w_widx),
         .i_wdata (wdata),
         .i_ridx  (w_ridx[gb]),
         .o_rdata (w_bank_rdata[gb])
      );
   end

   assign w_op1 = live(req_rsel1) ? w_bank_rdata[bsel(req_rsel1)] : '0;
   assign w_op2 = live(w_rs2)     ? w_bank_rdata[bsel(w_rs2)]     : '0;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_accept) w_next = w_conflict ? CONFLICT : RESP;
         end
         CONFLICT: begin
            w_next = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               if (w_accept) w_next = w_conflict ? CONFLICT : RESP;
               else          w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= IDLE;
         r_rsel2  <= '0;
         r_hold1  <= '0;
         r_rdata1 <= '0;
         r_rdata2 <= '0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_rsel2 <= req_rsel2;
            if (w_conflict) begin
               r_hold1 <= w_op1;
               if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            end else begin
               r_rdata1 <= w_op1;
               r_rdata2 <= w_op2;
            end
         end else if (r_state == CONFLICT) begin
            r_rdata1 <= r_hold1;
            r_rdata2 <= w_op2;
         end
      end
   end

   assign rsp_valid      = (r_state == RESP);
   assign rsp_rdata1     = r_rdata1;
   assign rsp_rdata2     = r_rdata2;
   assign conflict_count = r_cnt;

endmodule

// File: tb/tb_vector_register_file_banked.sv
// tb/tb_vector_register_file_banked.sv - scoreboard bench for vector_register_file_banked
module tb_vector_register_file_banked;
   import cpu_types_pkg::*;

   localparam int T  = 4;
   localparam int NR = 32;
   localparam int NB = 4;
   localparam int CW = 3;

   typedef logic [T*WORD_W-1:0] vec_t;
   typedef struct packed { vec_t a; vec_t b; } exp_t;

   logic             CLK = 1'b0;
   logic             nRST = 1'b0;
   logic             req_valid, req_ready, rsp_valid, rsp_ready;
   regbits_t         req_rsel1, req_rsel2, wsel;
   word_t [T-1:0]    rsp_rdata1, rsp_rdata2, wdata;
   logic [T-1:0]     wen;
   logic [CW-1:0]    conflict_count;

   always #5 CLK = ~CLK;

   vector_register_file_banked #(
      .THREADS (T), .NREGS (NR), .NBANKS (NB), .CNT_W (CW)
   ) dut (
      .CLK (CLK), .nRST (nRST),
      .req_valid (req_valid), .req_ready (req_ready),
      .req_rsel1 (req_rsel1), .req_rsel2 (req_rsel2),
      .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
      .rsp_rdata1 (rsp_rdata1), .rsp_rdata2 (rsp_rdata2),
      .wen (wen), .wsel (wsel), .wdata (wdata),
      .conflict_count (conflict_count)
   );

   int   checks = 0;
   int   passes = 0;
   exp_t q[$];
   vec_t mem [NR];
   bit   pend, resp_out;
   vec_t hold1;
   int   hold_r2;
   int   exp_cnt;

   task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t rd(int r);
      if (r == 0 || r >= NR) return '0;
      return mem[r];
   endfunction

   function automatic bit is_conf(int a, int b);
      return ((a % NB) == (b % NB)) && (a != b) && (a != 0) && (b != 0);
   endfunction

   task automatic reset_model();
      for (int r = 0; r < NR; r++) mem[r] = '0;
      q.delete();
      pend = 0; resp_out = 0; exp_cnt = 0; hold1 = '0; hold_r2 = 0;
   endtask

   // Reference model: a read sees the register contents after this cycle's write.
   always @(negedge CLK) begin
      bit   exp_ready;
      int   r1, r2;
      if (nRST) begin
         exp_ready = !pend && (!resp_out || rsp_ready);
         chk("req_ready", req_ready, exp_ready);
         chk("rsp_valid", rsp_valid, resp_out);
         chk("conflict_count", conflict_count, exp_cnt);
         if (int'(wsel) != 0 && int'(wsel) < NR)
            for (int l = 0; l < T; l++)
               if (wen[l]) mem[wsel][l*WORD_W +: WORD_W] = wdata[l];
         if (pend) begin
            q.push_back({hold1, rd(hold_r2)});
            pend = 0;
            resp_out = 1;
         end else if (resp_out && rsp_ready) begin
            resp_out = 0;
         end
         if (req_valid && exp_ready) begin
            r1 = int'(req_rsel1);
            r2 = int'(req_rsel2);
            if (is_conf(r1, r2)) begin
               hold1 = rd(r1); hold_r2 = r2; pend = 1;
               if (exp_cnt < (1 << CW) - 1) exp_cnt++;
            end else begin
               q.push_back({rd(r1), rd(r2)});
               resp_out = 1;
            end
         end
      end
   end

   // Monitor: compares every presented response against the queue head.
   always @(negedge CLK) begin
      if (nRST && rsp_valid) begin
         if (q.size() == 0) begin
            checks++;
            $display("FAIL rsp_unexpected: got response %0h/%0h expected none", rsp_rdata1, rsp_rdata2);
         end else begin
            chk("rdata1", rsp_rdata1, q[0].a);
            chk("rdata2", rsp_rdata2, q[0].b);
            if (rsp_ready) void'(q.pop_front());
         end
      end
   end

   task automatic drive(bit rv, int r1, int r2, bit rr, logic [T-1:0] we, int ws, vec_t wd);
      req_valid = rv;
      req_rsel1 = regbits_t'(r1);
      req_rsel2 = regbits_t'(r2);
      rsp_ready = rr;
      wen       = we;
      wsel      = regbits_t'(ws);
      wdata     = wd;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 1, '0, 0, '0);
   endtask

   initial begin
      int r1, r2;
      reset_model();
      req_valid = 0; req_rsel1 = '0; req_rsel2 = '0; rsp_ready = 1;
      wen = '0; wsel = '0; wdata = '0;
      repeat (2) @(posedge CLK);
      #1 nRST = 1'b1;
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_count", conflict_count, 0);
      chk("reset_req_ready", req_ready, 1);
      chk("reset_rdata1", rsp_rdata1, 0);

      // r3/r5 after reset: latency 1, all zero
      drive(1, 3, 5, 1, '0, 0, '0);
      chk("lat1_valid", rsp_valid, 1);
      idle();

      // partial-lane write to r6, then r6/r6
      drive(0, 0, 0, 1, 4'b0101, 6, {32'h44, 32'h33, 32'h22, 32'h11});
      drive(1, 6, 6, 1, '0, 0, '0);
      chk("r6_lanes", rsp_rdata1, {32'h0, 32'h33, 32'h0, 32'h11});
      idle();

      // conflict r1/r5
      drive(0, 0, 0, 1, 4'hF, 1, {4{32'hA}});
      drive(0, 0, 0, 1, 4'hF, 5, {4{32'hB}});
      drive(1, 1, 5, 1, '0, 0, '0);
      chk("conflict_stall", req_ready, 0);
      chk("conflict_no_rsp", rsp_valid, 0);
      idle();
      chk("lat2_valid", rsp_valid, 1);
      chk("lat2_rdata2", rsp_rdata2, {4{32'hB}});
      idle();

      // same-cycle write bypass, and r0 writes ignored
      drive(1, 2, 0, 1, 4'hF, 2, {4{32'h77}});
      chk("bypass_rdata1", rsp_rdata1, {4{32'h77}});
      idle();
      drive(0, 0, 0, 1, 4'hF, 0, {4{32'hFF}});
      drive(1, 0, 0, 1, '0, 0, '0);
      idle();

      // stalled response, then drain with a back-to-back request
      drive(1, 3, 6, 0, '0, 0, '0);
      repeat (3) drive(0, 0, 0, 0, 4'hF, 3, {4{$urandom}});
      drive(1, 7, 6, 1, '0, 0, '0);
      chk("b2b_valid", rsp_valid, 1);
      idle();

      // reset while in CONFLICT
      drive(0, 0, 0, 1, 4'hF, 9, {4{32'h99}});
      drive(1, 1, 5, 1, '0, 0, '0);
      nRST = 1'b0;
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_count", conflict_count, 0);
      reset_model();
      @(posedge CLK);
      #1 nRST = 1'b1;
      drive(1, 9, 1, 1, '0, 0, '0);
      chk("rst_storage", rsp_rdata1, 0);
      idle();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r1 = $urandom_range(0, NR - 1);
         r2 = ($urandom_range(0, 1) != 0) ? (r1 ^ (NB * $urandom_range(0, 7))) : $urandom_range(0, NR - 1);
         drive($urandom_range(0, 3) != 0, r1, r2, $urandom_range(0, 3) != 0,
               T'($urandom), $urandom_range(0, NR - 1), {$urandom, $urandom, $urandom, $urandom});
      end
      repeat (5) idle();
      chk("scoreboard_drain", q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
